div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle divider sequencer for the execute stage. Accepts DIV/DIVU operands and runs a
//  radix-2 restoring shift-subtract over DATA_W cycles. Returns {remainder, quotient} for the
//  HI/LO write path. Drives the execute-stage stall request and honours pipeline flush (annul).
// PARAMETERS
//  DATA_W  32  operand width; quotient/remainder width
//  CNT_W   6   iteration counter width; must hold DATA_W
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  div_start_i   in   1         execute stage holds a DIV/DIVU (level, held while stalled)
//  div_signed_i  in   1         1=DIV signed, 0=DIVU
//  annul_i       in   1         flush/exception: abandon current operation
//  dividend_i    in   DATA_W    rs operand (sampled in FREE only)
//  divisor_i     in   DATA_W    rt operand (sampled in FREE only)
//  div_res_o     out  2*DATA_W  {remainder, quotient}, valid while div_ready_o
//  div_ready_o   out  1         result valid
//  div_busy_o    out  1         state is ON or BYZERO
//  stallreq_o    out  1         = div_start_i & ~div_ready_o & ~annul_i (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FREE, cnt=0, div_res_o=0, div_ready_o=0, div_busy_o=0.
//  States: FREE, BYZERO, ON, END.
//  FREE: div_start_i & ~annul_i: divisor==0 -> BYZERO; else latch |dividend|, |divisor|
//    (two's-complement magnitude only when div_signed_i), sign flags, cnt=0 -> ON.
//    Otherwise hold div_res_o=0, div_ready_o=0.
//  BYZERO: one cycle -> END with div_res_o=0.
//  ON: per cycle {rem,dvd}<<=1; if rem>=divisor {rem-=divisor; quotient bit=1}; cnt++.
//    After DATA_W iterations -> END. Quotient negated if sign(dividend)^sign(divisor) and
//    signed; remainder negated if dividend negative and signed (sign follows dividend).
//  END: div_ready_o=1, div_res_o held stable. Stays in END while div_start_i=1;
//    div_start_i=0 -> FREE, ready drops next cycle.
//  Latency: start seen in cycle 0 -> ready high in cycle DATA_W+1 (33 for 32-bit);
//    divide-by-zero -> ready in cycle 2.
//  annul_i=1 in any state -> FREE next edge, ready=0, result discarded; annul has
//    priority over start in the same cycle.
//  Operands change while ON: ignored (latched copies used).
//  Overflow -2^(DATA_W-1) / -1 signed: quotient wraps to 0x80000000, remainder 0, no trap.
//  Back-to-back divides: a new start is accepted only from FREE; the instruction that
//    consumed the result must deassert div_start_i for at least one cycle.
//  Reset asserted mid-operation: immediate return to reset values, no partial result.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in FREE, if |dividend| < |divisor| (divisor!=0), skip ON and
//    go direct to END next cycle with quotient=0, remainder=dividend (original sign);
//    latency 2 cycles.
//  Not defined: every non-zero divisor takes the full DATA_W iterations; no comparator.
// TESTING
//  DIVU 100/7 -> ready at cycle 33, div_res_o={32'd2, 32'd14}; stallreq_o high cycles 0-32.
//  DIV -7/2 signed -> {32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quot -3).
//  DIV 32'h80000000 / 32'hFFFFFFFF -> {32'h0, 32'h80000000}, no hang.
//  DIVU 5/0 -> ready at cycle 2, div_res_o=0, stallreq_o low from cycle 2.
//  annul_i pulsed at cycle 10 of ON -> FREE at cycle 11, ready never asserts; next start
//    runs full 33 cycles with correct result.
//  DIV_EARLY_OUT_EN: DIVU 3/10 -> ready at cycle 2, {32'd3, 32'd0}; undefined -> cycle 33,
//    same value.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for the execute stage.
// Handles DIV/DIVU, drives the stall request and honours pipeline annul.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iterations when |dividend| < |divisor|).
module div_seq_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start_i,
    input  logic                  div_signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    output logic [2*DATA_W-1:0]   div_res_o,
    output logic                  div_ready_o,
    output logic                  div_busy_o,
    output logic                  stallreq_o
);

    localparam int unsigned RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   abs_dvd, abs_dvs;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   rem_diff, rem_nx, dvd_nx, quot_fix, rem_fix;
    logic                q_bit;

    // Operand magnitudes; two's-complement negation only for signed DIV
    always_comb begin
        abs_dvd = (div_signed_i && dividend_i[DATA_W-1]) ? DATA_W'(-dividend_i) : dividend_i;
        abs_dvs = (div_signed_i && divisor_i[DATA_W-1])  ? DATA_W'(-divisor_i)  : divisor_i;
    end

    // One restoring shift-subtract step plus final sign correction
    always_comb begin
        rem_sh   = {rem_q, dvd_q[DATA_W-1]};
        q_bit    = (rem_sh >= {1'b0, dvs_q});
        rem_diff = rem_sh[DATA_W-1:0] - dvs_q;
        rem_nx   = q_bit ? rem_diff : rem_sh[DATA_W-1:0];
        dvd_nx   = {dvd_q[DATA_W-2:0], q_bit};
        quot_fix = neg_quot_q ? DATA_W'(-dvd_nx) : dvd_nx;
        rem_fix  = neg_rem_q  ? DATA_W'(-rem_nx) : rem_nx;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        res_d      = res_q;
        ready_d    = ready_q;

        if (annul_i) begin
            state_d = ST_FREE;
            cnt_d   = '0;
            res_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    res_d   = '0;
                    ready_d = 1'b0;
                    if (div_start_i) begin
                        neg_quot_d = div_signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        neg_rem_d  = div_signed_i & dividend_i[DATA_W-1];
                        dvs_d      = abs_dvs;
                        cnt_d      = '0;
                        if (divisor_i == '0) begin
                            rem_d   = '0;
                            dvd_d   = '0;
                            state_d = ST_BYZERO;
`ifdef DIV_EARLY_OUT_EN
                        end else if (abs_dvd < abs_dvs) begin
                            // Result known up front: quotient 0, remainder is the raw dividend
                            rem_d   = dividend_i;
                            dvd_d   = '0;
                            state_d = ST_BYZERO;
`endif
                        end else begin
                            rem_d   = '0;
                            dvd_d   = abs_dvd;
                            state_d = ST_ON;
                        end
                    end
                end
                ST_BYZERO: begin
                    res_d   = {rem_q, dvd_q};
                    ready_d = 1'b1;
                    state_d = ST_END;
                end
                ST_ON: begin
                    rem_d = rem_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        res_d   = {rem_fix, quot_fix};
                        ready_d = 1'b1;
                        state_d = ST_END;
                    end
                end
                ST_END: begin
                    if (!div_start_i) begin
                        res_d   = '0;
                        ready_d = 1'b0;
                        state_d = ST_FREE;
                    end
                end
                default: begin
                    state_d = ST_FREE;
                end
            endcase
        end

        busy_d = (state_d == ST_ON) || (state_d == ST_BYZERO);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            res_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            res_q      <= res_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign div_res_o   = res_q;
    assign div_ready_o = ready_q;
    assign div_busy_o  = busy_q;
    assign stallreq_o  = div_start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl against an arithmetic reference model.
// Honours DIV_EARLY_OUT_EN when computing expected latency.
module tb_div_seq_ctrl;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        div_start_i;
    logic        div_signed_i;
    logic        annul_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [63:0] div_res_o;
    logic        div_ready_o;
    logic        div_busy_o;
    logic        stallreq_o;

    int errs;
    int checks;

    div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .annul_i      (annul_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .div_res_o    (div_res_o),
        .div_ready_o  (div_ready_o),
        .div_busy_o   (div_busy_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic gives truncating division with remainder following dividend
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                  output logic [63:0] res, output int lat);
        longint sa, sb, q, r, ma, mb;
        if (b == 32'd0) begin
            res = 64'd0;
            lat = 2;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'(a);
            sb = sgn ? longint'($signed(b)) : longint'(b);
            q  = sa / sb;
            r  = sa % sb;
            res = {r[31:0], q[31:0]};
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            lat = (EARLY && (ma < mb)) ? 2 : 33;
        end
    endfunction

    // Issue one divide; scramble operands while it runs; return result, ready cycle, stall-low cycle
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           output logic [63:0] res, output int lat, output int stall_lo);
        @(posedge clk); #1;
        dividend_i   = a;
        divisor_i    = b;
        div_signed_i = sgn;
        div_start_i  = 1'b1;
        #1;
        stall_lo = stallreq_o ? -1 : 0;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            dividend_i = $urandom;
            divisor_i  = $urandom;
            if (stall_lo < 0 && !stallreq_o) stall_lo = lat;
            if (div_ready_o || lat >= 100) break;
        end
        res = div_res_o;
    endtask

    // Release the start level and let the sequencer return to FREE
    task automatic end_div();
        @(posedge clk); #1;
        div_start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input bit sgn);
        logic [63:0] exp_res, res;
        int exp_lat, lat, stall_lo;
        model(a, b, sgn, exp_res, exp_lat);
        run_div(a, b, sgn, res, lat, stall_lo);
        checks++;
        if (res !== exp_res) begin
            errs++;
            $display("FAIL %s result a=%h b=%h s=%0d: got %h expected %h", name, a, b, sgn, res, exp_res);
        end
        checks++;
        if (lat != exp_lat) begin
            errs++;
            $display("FAIL %s latency a=%h b=%h: got %0d expected %0d", name, a, b, lat, exp_lat);
        end
        checks++;
        if (stall_lo != exp_lat) begin
            errs++;
            $display("FAIL %s stall release: got cycle %0d expected %0d", name, stall_lo, exp_lat);
        end
        end_div();
        checks++;
        if (div_ready_o !== 1'b0 || div_res_o !== 64'd0) begin
            errs++;
            $display("FAIL %s release: ready=%b res=%h expected 0/0", name, div_ready_o, div_res_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        div_start_i = 1'b0; div_signed_i = 1'b0; annul_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (div_ready_o !== 1'b0) begin errs++; $display("FAIL reset ready: got %b expected 0", div_ready_o); end
        checks++;
        if (div_busy_o !== 1'b0) begin errs++; $display("FAIL reset busy: got %b expected 0", div_busy_o); end
        checks++;
        if (div_res_o !== 64'd0) begin errs++; $display("FAIL reset res: got %h expected 0", div_res_o); end
        checks++;
        if (stallreq_o !== 1'b0) begin errs++; $display("FAIL reset stall: got %b expected 0", stallreq_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("divu_100_7", 32'd100, 32'd7, 1'b0);
        check_op("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1);
        check_op("div_overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        check_op("divu_by_zero", 32'd5, 32'd0, 1'b0);
        check_op("divu_3_10", 32'd3, 32'd10, 1'b0);
        check_op("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1);
        check_op("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h80000000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 300));
                2:       b = $urandom;
                default: b = 32'hFFFFFFFF;
            endcase
            check_op("random", a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_annul();
        @(posedge clk); #1;
        dividend_i = 32'd1000; divisor_i = 32'd3; div_signed_i = 1'b0; div_start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (div_busy_o !== 1'b1) begin errs++; $display("FAIL annul busy_on: got %b expected 1", div_busy_o); end
        annul_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin errs++; $display("FAIL annul stall: got %b expected 0", stallreq_o); end
        @(posedge clk); #1;
        annul_i = 1'b0;
        div_start_i = 1'b0;
        checks++;
        if (div_busy_o !== 1'b0 || div_ready_o !== 1'b0 || div_res_o !== 64'd0) begin
            errs++;
            $display("FAIL annul free: busy=%b ready=%b res=%h expected 0/0/0", div_busy_o, div_ready_o, div_res_o);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (div_ready_o !== 1'b0) begin errs++; $display("FAIL annul no_ready: got %b expected 0", div_ready_o); end
        // Annul beats start when both arrive in FREE
        div_start_i = 1'b1; annul_i = 1'b1; divisor_i = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (div_busy_o !== 1'b0) begin errs++; $display("FAIL annul priority: busy=%b expected 0", div_busy_o); end
        div_start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;
        check_op("after_annul", 32'd1000, 32'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_res, res;
        int exp_lat, lat, stall_lo, bad;
        model(32'hFFFFFF00, 32'd9, 1'b1, exp_res, exp_lat);
        run_div(32'hFFFFFF00, 32'd9, 1'b1, res, lat, stall_lo);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (div_ready_o !== 1'b1 || div_res_o !== exp_res) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL hold_end: ready=%b res=%h expected 1/%h", div_ready_o, div_res_o, exp_res);
        end
        end_div();
        checks++;
        if (div_ready_o !== 1'b0) begin errs++; $display("FAIL b2b drop: ready=%b expected 0", div_ready_o); end
        check_op("b2b_second", 32'd123456789, 32'd1000, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        dividend_i = 32'd77777; divisor_i = 32'd13; div_signed_i = 1'b0; div_start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (div_ready_o !== 1'b0 || div_busy_o !== 1'b0 || div_res_o !== 64'd0) begin
            errs++;
            $display("FAIL reset_mid: ready=%b busy=%b res=%h expected 0/0/0", div_ready_o, div_busy_o, div_res_o);
        end
        div_start_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_op("after_reset", 32'd77777, 32'd13, 1'b0);
    endtask

    initial begin
        errs = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
